// File: rtl/branch_predict_ctrl.sv
// Branch prediction and misprediction recovery for a 5-stage pipeline.
// The IF stage reads a 2-bit counter table; the EX stage trains it and triggers a one-cycle redirect and flush.
module branch_predict_ctrl #(
  parameter int BHT_ENTRIES = 16,
  parameter int PC_W        = 32,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PC_W-1:0]  if_pc,
  output logic             if_pred_taken,
  input  logic             ex_valid,
  input  logic             ex_stall,
  input  logic             ex_is_branch,
  input  logic [PC_W-1:0]  ex_pc,
  input  logic             ex_pred_taken,
  input  logic             ex_taken,
  input  logic [PC_W-1:0]  ex_target,
  output logic             redirect_valid,
  output logic [PC_W-1:0]  redirect_pc,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  localparam logic [1:0]       CTR_MIN   = 2'b00;
  localparam logic [1:0]       CTR_WNT   = 2'b01;
  localparam logic [1:0]       CTR_MAX   = 2'b11;
  localparam logic [1:0]       CTR_STEP  = 2'b01;
  localparam logic [PC_W-1:0]  PC_STEP   = {{(PC_W-3){1'b0}}, 3'b100};
  localparam logic [PC_W-1:0]  PC_ZERO   = {PC_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_SAT   = {CNT_W{1'b1}};

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       bht_q [BHT_ENTRIES];
  logic [1:0]       bht_wr;
  logic [IDX_W-1:0] if_idx;
  logic [IDX_W-1:0] ex_idx;
  logic             resolve;
  logic             mispredict;

  logic             redirect_valid_q, redirect_valid_d;
  logic             flush_ifid_q, flush_ifid_d;
  logic             flush_idex_q, flush_idex_d;
  logic [PC_W-1:0]  redirect_pc_q, redirect_pc_d;
  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;
  logic             unused_if_pc_bits;

  // 2-bit saturating counter step toward the resolved direction
  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    if (taken) begin
      nxt = (ctr == CTR_MAX) ? ctr : ctr + CTR_STEP;
    end else begin
      nxt = (ctr == CTR_MIN) ? ctr : ctr - CTR_STEP;
    end
    return nxt;
  endfunction

  function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cnt, input logic inc);
    logic [CNT_W-1:0] nxt;
    if (inc && (cnt != CNT_SAT)) begin
      nxt = cnt + CNT_ONE;
    end else begin
      nxt = cnt;
    end
    return nxt;
  endfunction

  assign if_idx            = if_pc[IDX_W+1:2];
  assign ex_idx            = ex_pc[IDX_W+1:2];
  assign unused_if_pc_bits = ^{if_pc[PC_W-1:IDX_W+2], if_pc[1:0]};

  // The read sees the registered table only, so a same-cycle write is not bypassed
  assign if_pred_taken = bht_q[if_idx][1];

  // Wrong-path EX contents during FLUSH are ignored through the IDLE qualifier
  assign resolve    = ex_valid & ~ex_stall & ex_is_branch & (state_q == ST_IDLE);
  assign mispredict = resolve & (ex_taken != ex_pred_taken);
  assign bht_wr     = ctr_next(bht_q[ex_idx], ex_taken);

  // Counter table: weakly not-taken after reset, trained on every resolve
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        bht_q[i] <= CTR_WNT;
      end
    end else if (resolve) begin
      bht_q[ex_idx] <= bht_wr;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  state_d = mispredict ? ST_FLUSH : ST_IDLE;
      ST_FLUSH: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM output logic, decoded from the next state so the flops mirror FLUSH
  always_comb begin
    redirect_valid_d = 1'b0;
    flush_ifid_d     = 1'b0;
    flush_idex_d     = 1'b0;
    case (state_d)
      ST_FLUSH: begin
        redirect_valid_d = 1'b1;
        flush_ifid_d     = 1'b1;
        flush_idex_d     = 1'b1;
      end
      ST_IDLE: begin
        redirect_valid_d = 1'b0;
        flush_ifid_d     = 1'b0;
        flush_idex_d     = 1'b0;
      end
      default: begin
        redirect_valid_d = 1'b0;
        flush_ifid_d     = 1'b0;
        flush_idex_d     = 1'b0;
      end
    endcase
  end

  // Redirect target and performance counter next values
  always_comb begin
    redirect_pc_d = redirect_pc_q;
    if (mispredict) begin
      redirect_pc_d = ex_taken ? ex_target : (ex_pc + PC_STEP);
    end else begin
      redirect_pc_d = redirect_pc_q;
    end
    branch_cnt_d  = cnt_next(branch_cnt_q, resolve);
    mispred_cnt_d = cnt_next(mispred_cnt_q, mispredict);
  end

  // Registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_valid_q <= 1'b0;
      flush_ifid_q     <= 1'b0;
      flush_idex_q     <= 1'b0;
      redirect_pc_q    <= PC_ZERO;
      branch_cnt_q     <= CNT_ZERO;
      mispred_cnt_q    <= CNT_ZERO;
    end else begin
      redirect_valid_q <= redirect_valid_d;
      flush_ifid_q     <= flush_ifid_d;
      flush_idex_q     <= flush_idex_d;
      redirect_pc_q    <= redirect_pc_d;
      branch_cnt_q     <= branch_cnt_d;
      mispred_cnt_q    <= mispred_cnt_d;
    end
  end

  assign redirect_valid = redirect_valid_q;
  assign flush_ifid     = flush_ifid_q;
  assign flush_idex     = flush_idex_q;
  assign redirect_pc    = redirect_pc_q;
  assign branch_cnt     = branch_cnt_q;
  assign mispred_cnt    = mispred_cnt_q;

endmodule
